// File: rtl/wb_writer_if.sv
// Bundle of the write-back queue's producer, register-file and hazard-query signals.
// master = pipeline side, slave = wb_writer.
interface wb_writer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            reg_wr;
  logic [4:0]      wa;
  logic [XLEN-1:0] wda;
  logic [4:0]      ra;
  logic [4:0]      rb;
  logic            haz_a;
  logic            haz_b;
  logic [CW-1:0]   count;

  modport master (
    output flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, ra, rb,
    input  alu_ready, lsu_ready, reg_wr, wa, wda, haz_a, haz_b, count
  );

  modport slave (
    input  flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, ra, rb,
    output alu_ready, lsu_ready, reg_wr, wa, wda, haz_a, haz_b, count
  );
endinterface

// File: rtl/wb_writer.sv
// In-order write-back queue: merges ALU and LSU results, drains one per cycle to the
// register file write port and reports RAW hazards for the two decode read addresses.
module wb_writer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  wb_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [4:0]      rd_mem_d   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   lsu_slot;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] wda_q, wda_d;

  logic            alu_ready, lsu_ready;
  logic            alu_push, lsu_push, pop;
  logic [AW-1:0]   offset [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic            haz_a, haz_b;

  // Ready looks only at the registered count; a pop in the same cycle frees nothing.
  always_comb begin
    alu_ready = count_q < CW'(DEPTH);
    lsu_ready = (count_q <= CW'(DEPTH - 2)) || (!bus.alu_valid && (count_q < CW'(DEPTH)));
    alu_push  = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    lsu_push  = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
    pop       = (count_q != '0) && !bus.flush;
  end

  always_comb begin
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    entry_vld = '0;
    offset    = '{default: '0};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset[i]    = AW'(i) - rd_ptr_q;
      entry_vld[i] = {1'b0, offset[i]} < count_q;
      if (entry_vld[i] && (bus.ra != 5'd0) && (rd_mem_q[i] == bus.ra)) haz_a = 1'b1;
      if (entry_vld[i] && (bus.rb != 5'd0) && (rd_mem_q[i] == bus.rb)) haz_b = 1'b1;
    end
  end

  // wa/wda are registered copies of the next head, taken from the post-update queue so
  // an entry pushed into an empty queue is presented right after the accepting edge.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wa_d       = wa_q;
    wda_d      = wda_q;
    lsu_slot   = wr_ptr_q + AW'(alu_push);
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (alu_push) begin
        rd_mem_d[wr_ptr_q]   = bus.alu_rd;
        data_mem_d[wr_ptr_q] = bus.alu_data;
      end
      if (lsu_push) begin
        rd_mem_d[lsu_slot]   = bus.lsu_rd;
        data_mem_d[lsu_slot] = bus.lsu_data;
      end
      wr_ptr_d = wr_ptr_q + AW'(alu_push) + AW'(lsu_push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(alu_push) + CW'(lsu_push) - CW'(pop);
      if (count_d != '0) begin
        wa_d  = rd_mem_d[rd_ptr_d];
        wda_d = data_mem_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wa_q     <= '0;
      wda_q    <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wa_q       <= wa_d;
      wda_q      <= wda_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.reg_wr    = pop;
  assign bus.wa        = wa_q;
  assign bus.wda       = wda_q;
  assign bus.haz_a     = haz_a;
  assign bus.haz_b     = haz_b;
  assign bus.count     = count_q;
endmodule
